// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
//
// Purpose: shares this core's single ring token and ring output port between
// two local ring masters. Port A is the coherent data cache and port B is the
// messenger/IO unit. The arbiter:
//   - captures a circulating Token slot for a requesting master;
//   - holds ownership while that master sends its burst;
//   - muxes the masters' slots onto the ring;
//   - reinjects the token once the owner is done.
// Grants alternate round-robin between A and B.
//
// Ports:
//   clock, reset        : single clock; synchronous active-low reset
//   whichCore [3:0]     : this core's ring ID, used as Source of a reinjected token
//   RingIn/SlotTypeIn/SourceIn  [31:0]/[3:0]/[3:0] : incoming ring slot
//   aWantsToken, bWantsToken     : master requests the token
//   aDriveRing, bDriveRing       : master drives the ring this cycle
//   a*/b* RingOut/SlotTypeOut/SourceOut : master slot data
//   aAcquireToken, bAcquireToken : token granted this cycle (combinational)
//   RingOut/SlotTypeOut/SourceOut: outgoing ring slot (combinational)
//   owner [1:0]         : 0 none, 1 A, 2 B (registered)
//   errFlags [2:0]      : sticky; bit0 drive collision, bit1 hold overrun,
//                         bit2 token seen while holding
module ring_token_arbiter #(
  parameter int unsigned MAXHOLD = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  whichCore,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  input  logic        aWantsToken,
  input  logic        bWantsToken,
  input  logic        aDriveRing,
  input  logic        bDriveRing,
  input  logic [31:0] aRingOut,
  input  logic [3:0]  aSlotTypeOut,
  input  logic [3:0]  aSourceOut,
  input  logic [31:0] bRingOut,
  input  logic [3:0]  bSlotTypeOut,
  input  logic [3:0]  bSourceOut,
  output logic        aAcquireToken,
  output logic        bAcquireToken,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  output logic [1:0]  owner,
  output logic [2:0]  errFlags
);

  localparam logic [3:0] SLOT_NULL  = 4'd7;
  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [7:0] MAXHOLD_C  = 8'(MAXHOLD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD_A  = 2'd1,
    ST_HOLD_B  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;          // 0: A has priority, 1: B has priority
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [2:0]  err_q, err_d;
  logic [1:0]  owner_q, owner_d;

  // Decode shared by the next-state and output processes. While reset is
  // held low the arbiter behaves as if idle with no owner: no grants, no
  // reinjection, and only a driving master can override the pass-through.
  logic active;
  logic token_in, null_in;
  logic hold_a, hold_b, in_idle;
  logic grant_a, grant_b;
  logic inject;
  logic collision;

  assign active    = reset;
  assign token_in  = (SlotTypeIn == SLOT_TOKEN);
  assign null_in   = (SlotTypeIn == SLOT_NULL);
  assign hold_a    = active && (state_q == ST_HOLD_A);
  assign hold_b    = active && (state_q == ST_HOLD_B);
  assign in_idle   = active && (state_q == ST_IDLE);
  assign grant_a   = in_idle && token_in && aWantsToken && (!bWantsToken || !rr_q);
  assign grant_b   = in_idle && token_in && bWantsToken && (!aWantsToken ||  rr_q);
  assign inject    = active && (state_q == ST_RELEASE) && null_in &&
                     !aDriveRing && !bDriveRing;
  // When someone owns the token and both drive, the owner's slot wins
  // without error. Only an ownerless double drive is a collision.
  assign collision = aDriveRing && bDriveRing && !hold_a && !hold_b;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      hold_cnt_q <= 8'd0;
      err_q      <= 3'b000;
      owner_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
      owner_q    <= owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    hold_cnt_d = hold_cnt_q;
    err_d      = err_q;

    if (collision) begin
      err_d[0] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_a) begin
          state_d    = ST_HOLD_A;
          hold_cnt_d = 8'd0;
        end else if (grant_b) begin
          state_d    = ST_HOLD_B;
          hold_cnt_d = 8'd0;
        end
      end

      ST_HOLD_A, ST_HOLD_B: begin
        if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
        // The overrun flag becomes visible together with the counter
        // reaching MAXHOLD. Ownership is never forcibly revoked.
        if (hold_cnt_d == MAXHOLD_C) begin
          err_d[1] = 1'b1;
        end
        // A second token on the ring while we hold one is a ring-level fault.
        if (token_in) begin
          err_d[2] = 1'b1;
        end
        if (state_q == ST_HOLD_A) begin
          if (!aWantsToken && !aDriveRing) begin
            state_d = ST_RELEASE;
          end
        end else begin
          if (!bWantsToken && !bDriveRing) begin
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        // The token must circulate before anyone here can take it again.
        // This prevents a direct hand-off between A and B.
        if (inject) begin
          state_d = ST_IDLE;
          rr_d    = ~rr_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_HOLD_A: owner_d = 2'd1;
      ST_HOLD_B: owner_d = 2'd2;
      default:   owner_d = 2'd0;
    endcase
  end

  // Output logic
  always_comb begin
    aAcquireToken = grant_a;
    bAcquireToken = grant_b;
    owner         = owner_q;
    errFlags      = err_q;

    RingOut     = RingIn;
    SlotTypeOut = SlotTypeIn;
    SourceOut   = SourceIn;

    if (hold_a && aDriveRing) begin
      RingOut     = aRingOut;
      SlotTypeOut = aSlotTypeOut;
      SourceOut   = aSourceOut;
    end else if (hold_b && bDriveRing) begin
      RingOut     = bRingOut;
      SlotTypeOut = bSlotTypeOut;
      SourceOut   = bSourceOut;
    end else if (aDriveRing) begin
      // Covers a lone A driver and the ownerless collision (A wins).
      RingOut     = aRingOut;
      SlotTypeOut = aSlotTypeOut;
      SourceOut   = aSourceOut;
    end else if (bDriveRing) begin
      RingOut     = bRingOut;
      SlotTypeOut = bSlotTypeOut;
      SourceOut   = bSourceOut;
    end else if (inject) begin
      RingOut     = 32'd0;
      SlotTypeOut = SLOT_TOKEN;
      SourceOut   = whichCore;
    end
  end

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Bench for ring_token_arbiter. Directed scenarios check literal values.
// A randomized run compares every output each cycle against a behavioural
// model of the token protocol.
module tb_ring_token_arbiter;

  localparam int MAXHOLD = 16;
  localparam logic [3:0] T_NULL  = 4'd7;
  localparam logic [3:0] T_TOKEN = 4'd1;
  localparam logic [3:0] CORE_ID = 4'hA;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  whichCore;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn, SourceIn;
  logic        aWantsToken, bWantsToken, aDriveRing, bDriveRing;
  logic [31:0] aRingOut, bRingOut;
  logic [3:0]  aSlotTypeOut, aSourceOut, bSlotTypeOut, bSourceOut;
  logic        aAcquireToken, bAcquireToken;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut, SourceOut;
  logic [1:0]  owner;
  logic [2:0]  errFlags;

  always #5 clock = ~clock;

  ring_token_arbiter #(.MAXHOLD(MAXHOLD)) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .aWantsToken(aWantsToken), .bWantsToken(bWantsToken),
    .aDriveRing(aDriveRing), .bDriveRing(bDriveRing),
    .aRingOut(aRingOut), .aSlotTypeOut(aSlotTypeOut), .aSourceOut(aSourceOut),
    .bRingOut(bRingOut), .bSlotTypeOut(bSlotTypeOut), .bSourceOut(bSourceOut),
    .aAcquireToken(aAcquireToken), .bAcquireToken(bAcquireToken),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .owner(owner), .errFlags(errFlags)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // The model tracks who holds the token and whether a token is still owed
  // back to the ring.
  logic [1:0]  m_owner = 2'd0;   // 0 nobody, 1 A, 2 B
  bit          m_owed = 1'b0;    // token must still be put back on the ring
  bit          m_rr = 1'b0;      // 1 means B is preferred next time
  int          m_hold = 0;
  logic [2:0]  m_err = 3'b000;
  bit          e_acq_a, e_acq_b;
  logic [31:0] e_ring;
  logic [3:0]  e_type, e_src;

  task automatic model_comb();
    bit live;
    bit free;
    int who;  // 0 ring input, 1 A, 2 B, 3 our token
    live = (reset === 1'b1);
    free = live && (m_owner == 2'd0) && !m_owed && (SlotTypeIn == T_TOKEN);
    e_acq_a = free && aWantsToken && (!bWantsToken || !m_rr);
    e_acq_b = free && bWantsToken && (!aWantsToken ||  m_rr);
    if (live && m_owner == 2'd1 && aDriveRing)      who = 1;
    else if (live && m_owner == 2'd2 && bDriveRing) who = 2;
    else if (aDriveRing)                            who = 1;
    else if (bDriveRing)                            who = 2;
    else if (live && m_owed && SlotTypeIn == T_NULL) who = 3;
    else                                            who = 0;
    case (who)
      1:       begin e_ring = aRingOut; e_type = aSlotTypeOut; e_src = aSourceOut; end
      2:       begin e_ring = bRingOut; e_type = bSlotTypeOut; e_src = bSourceOut; end
      3:       begin e_ring = 32'd0;    e_type = T_TOKEN;      e_src = whichCore;  end
      default: begin e_ring = RingIn;   e_type = SlotTypeIn;   e_src = SourceIn;   end
    endcase
  endtask

  task automatic model_seq();
    model_comb();
    if (reset !== 1'b1) begin
      m_owner = 2'd0; m_owed = 1'b0; m_rr = 1'b0; m_hold = 0; m_err = 3'b000;
      return;
    end
    if (aDriveRing && bDriveRing && m_owner == 2'd0) m_err[0] = 1'b1;
    if (m_owner != 2'd0) begin
      if (m_hold < 255) m_hold = m_hold + 1;
      if (m_hold == MAXHOLD) m_err[1] = 1'b1;
      if (SlotTypeIn == T_TOKEN) m_err[2] = 1'b1;
      if ((m_owner == 2'd1 && !aWantsToken && !aDriveRing) ||
          (m_owner == 2'd2 && !bWantsToken && !bDriveRing)) begin
        m_owner = 2'd0;
        m_owed  = 1'b1;
      end
    end else if (m_owed) begin
      if (SlotTypeIn == T_NULL && !aDriveRing && !bDriveRing) begin
        m_owed = 1'b0;
        m_rr   = !m_rr;
      end
    end else if (e_acq_a) begin
      m_owner = 2'd1; m_hold = 0;
    end else if (e_acq_b) begin
      m_owner = 2'd2; m_hold = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_seq();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
    model_comb();
  endtask

  task automatic drive_slot(input logic [3:0] t);
    RingIn     = $urandom;
    SlotTypeIn = t;
    SourceIn   = 4'($urandom_range(0, 15));
  endtask

  task automatic masters(input bit aw, input bit ad, input bit bw, input bit bd);
    aWantsToken  = aw; aDriveRing = ad;
    bWantsToken  = bw; bDriveRing = bd;
    aRingOut     = $urandom;
    aSlotTypeOut = 4'($urandom_range(2, 6));
    aSourceOut   = 4'($urandom_range(0, 15));
    bRingOut     = $urandom;
    bSlotTypeOut = 4'($urandom_range(2, 6));
    bSourceOut   = 4'($urandom_range(0, 15));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    masters(0, 0, 0, 0);
    drive_slot(T_NULL);
    tick();
    reset = 1'b1;
  endtask

  // Owner drops want and drive; two Null slots let the token go home.
  task automatic release_owner();
    masters(0, 0, 0, 0);
    drive_slot(T_NULL);
    tick();
    drive_slot(T_NULL);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    masters(1, 0, 1, 0);
    drive_slot(T_TOKEN);
    tick();
    tick();
    settle();
    checks++;
    if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++;
    if (errFlags !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", errFlags); end
    checks++;
    if (aAcquireToken !== 1'b0 || bAcquireToken !== 1'b0) begin
      errors++; $display("FAIL reset_acq: got %b%b expected 00", aAcquireToken, bAcquireToken);
    end
    checks++;
    if (RingOut !== RingIn || SlotTypeOut !== T_TOKEN || SourceOut !== SourceIn) begin
      errors++; $display("FAIL reset_pass: got %h/%h/%h expected %h/%h/%h",
                         RingOut, SlotTypeOut, SourceOut, RingIn, T_TOKEN, SourceIn);
    end
    masters(0, 1, 0, 0);
    settle();
    checks++;
    if (RingOut !== aRingOut || SlotTypeOut !== aSlotTypeOut) begin
      errors++; $display("FAIL reset_drive: got %h/%h expected %h/%h", RingOut, SlotTypeOut, aRingOut, aSlotTypeOut);
    end
    tick();
    reset = 1'b1;
    masters(0, 0, 0, 0);
    drive_slot(T_NULL);
    tick();
  endtask

  task automatic test_single_grant();
    masters(1, 1, 0, 0);
    drive_slot(T_TOKEN);
    settle();
    checks++;
    if (aAcquireToken !== 1'b1 || bAcquireToken !== 1'b0) begin
      errors++; $display("FAIL grant_a_acq: got %b%b expected 10", aAcquireToken, bAcquireToken);
    end
    checks++;
    if (RingOut !== aRingOut) begin errors++; $display("FAIL grant_a_consume: got %h expected %h", RingOut, aRingOut); end
    tick();
    for (int i = 0; i < 10; i++) begin
      masters(1, 1, 0, 0);
      drive_slot(T_NULL);
      settle();
      checks++;
      if (owner !== 2'd1 || RingOut !== aRingOut || SlotTypeOut !== aSlotTypeOut) begin
        errors++; $display("FAIL burst_a[%0d]: got owner %0d ring %h expected owner 1 ring %h", i, owner, RingOut, aRingOut);
      end
      tick();
    end
    // Release detected this cycle: no token yet, Null passes through.
    masters(0, 0, 0, 0);
    drive_slot(T_NULL);
    settle();
    checks++;
    if (SlotTypeOut !== T_NULL) begin errors++; $display("FAIL release_early: got type %0d expected 7", SlotTypeOut); end
    tick();
    drive_slot(T_NULL);
    settle();
    checks++;
    if (owner !== 2'd0 || RingOut !== 32'd0 || SlotTypeOut !== T_TOKEN || SourceOut !== CORE_ID) begin
      errors++; $display("FAIL reinject_a: got owner %0d %h/%h/%h expected 0 0/1/%h",
                         owner, RingOut, SlotTypeOut, SourceOut, CORE_ID);
    end
    tick();
    // Round-robin now favours B.
    masters(1, 0, 1, 1);
    drive_slot(T_TOKEN);
    settle();
    checks++;
    if (aAcquireToken !== 1'b0 || bAcquireToken !== 1'b1) begin
      errors++; $display("FAIL rr_after_a: got %b%b expected 01", aAcquireToken, bAcquireToken);
    end
    tick();
    release_owner();
  endtask

  task automatic test_both_want();
    pulse_reset();
    masters(1, 1, 1, 0);
    drive_slot(T_TOKEN);
    settle();
    checks++;
    if (aAcquireToken !== 1'b1 || bAcquireToken !== 1'b0) begin
      errors++; $display("FAIL both_first: got %b%b expected 10", aAcquireToken, bAcquireToken);
    end
    tick();
    masters(1, 0, 1, 0);
    drive_slot(T_NULL);
    settle();
    checks++;
    if (owner !== 2'd1) begin errors++; $display("FAIL both_first_owner: got %0d expected 1", owner); end
    // A stops while B still wants: no direct hand-off, token must go out.
    masters(0, 0, 1, 0);
    tick();
    drive_slot(T_NULL);
    settle();
    checks++;
    if (owner !== 2'd0 || SlotTypeOut !== T_TOKEN || bAcquireToken !== 1'b0) begin
      errors++; $display("FAIL no_handoff: got owner %0d type %0d acqB %b expected 0 1 0", owner, SlotTypeOut, bAcquireToken);
    end
    tick();
    masters(1, 0, 1, 1);
    drive_slot(T_TOKEN);
    settle();
    checks++;
    if (aAcquireToken !== 1'b0 || bAcquireToken !== 1'b1) begin
      errors++; $display("FAIL both_second: got %b%b expected 01", aAcquireToken, bAcquireToken);
    end
    tick();
    masters(0, 0, 1, 1);
    settle();
    checks++;
    if (owner !== 2'd2 || RingOut !== bRingOut) begin
      errors++; $display("FAIL both_second_owner: got %0d %h expected 2 %h", owner, RingOut, bRingOut);
    end
    tick();
    release_owner();
  endtask

  task automatic test_no_wanter();
    logic [31:0] sent;
    masters(0, 0, 0, 0);
    drive_slot(T_TOKEN);
    sent = RingIn;
    settle();
    checks++;
    if (RingOut !== sent || SlotTypeOut !== T_TOKEN || aAcquireToken !== 1'b0 || bAcquireToken !== 1'b0) begin
      errors++; $display("FAIL token_pass: got %h/%0d acq %b%b expected %h/1 acq 00",
                         RingOut, SlotTypeOut, aAcquireToken, bAcquireToken, sent);
    end
    tick();
    drive_slot(T_NULL);
    settle();
    checks++;
    if (owner !== 2'd0) begin errors++; $display("FAIL token_pass_owner: got %0d expected 0", owner); end
    tick();
  endtask

  task automatic test_overrun();
    pulse_reset();
    masters(1, 1, 0, 0);
    drive_slot(T_TOKEN);
    tick();
    for (int k = 0; k < 20; k++) begin
      masters(1, 1, 0, 0);
      drive_slot(T_NULL);
      settle();
      checks++;
      if (owner !== 2'd1 || errFlags[1] !== (k >= MAXHOLD)) begin
        errors++; $display("FAIL overrun[%0d]: got owner %0d err1 %b expected 1 %b", k, owner, errFlags[1], (k >= MAXHOLD));
      end
      tick();
    end
    masters(0, 0, 0, 0);
    drive_slot(T_NULL);
    tick();
    drive_slot(T_NULL);
    settle();
    checks++;
    if (SlotTypeOut !== T_TOKEN || SourceOut !== CORE_ID || errFlags !== 3'b010) begin
      errors++; $display("FAIL overrun_release: got type %0d src %h err %b expected 1 %h 010", SlotTypeOut, SourceOut, errFlags, CORE_ID);
    end
    tick();
  endtask

  task automatic test_errors();
    pulse_reset();
    masters(0, 1, 0, 1);
    drive_slot(T_NULL);
    settle();
    checks++;
    if (RingOut !== aRingOut || errFlags[0] !== 1'b0) begin
      errors++; $display("FAIL collide_out: got %h err0 %b expected %h 0", RingOut, errFlags[0], aRingOut);
    end
    tick();
    masters(1, 1, 0, 0);
    drive_slot(T_TOKEN);
    settle();
    checks++;
    if (errFlags !== 3'b001) begin errors++; $display("FAIL collide_flag: got %b expected 001", errFlags); end
    tick();
    masters(1, 0, 0, 0);
    drive_slot(T_TOKEN);
    settle();
    checks++;
    if (SlotTypeOut !== T_TOKEN || RingOut !== RingIn || aAcquireToken !== 1'b0) begin
      errors++; $display("FAIL hold_token_pass: got %0d %h acq %b expected 1 %h 0", SlotTypeOut, RingOut, aAcquireToken, RingIn);
    end
    tick();
    drive_slot(T_NULL);
    settle();
    checks++;
    if (errFlags !== 3'b101 || owner !== 2'd1) begin
      errors++; $display("FAIL hold_token_flag: got %b owner %0d expected 101 1", errFlags, owner);
    end
    tick();
    release_owner();
  endtask

  task automatic test_reset_mid_hold();
    masters(0, 1, 0, 1);     // leaves a sticky collision flag
    drive_slot(T_NULL);
    tick();
    masters(0, 0, 1, 1);
    drive_slot(T_TOKEN);
    tick();
    masters(0, 0, 1, 1);
    drive_slot(T_NULL);
    tick();
    reset = 1'b0;
    masters(0, 0, 0, 0);
    drive_slot(T_NULL);
    settle();
    checks++;
    if (SlotTypeOut !== T_NULL) begin errors++; $display("FAIL rst_hold_noinj: got type %0d expected 7", SlotTypeOut); end
    tick();
    reset = 1'b1;
    drive_slot(T_NULL);
    settle();
    checks++;
    if (owner !== 2'd0 || errFlags !== 3'b000 || SlotTypeOut !== T_NULL) begin
      errors++; $display("FAIL rst_hold_state: got owner %0d err %b type %0d expected 0 000 7", owner, errFlags, SlotTypeOut);
    end
    tick();
    drive_slot(T_NULL);
    settle();
    checks++;
    if (SlotTypeOut !== T_NULL) begin errors++; $display("FAIL rst_hold_lost: got type %0d expected 7", SlotTypeOut); end
    masters(1, 1, 1, 0);
    drive_slot(T_TOKEN);
    settle();
    checks++;
    if (aAcquireToken !== 1'b1 || bAcquireToken !== 1'b0) begin
      errors++; $display("FAIL rst_hold_idle: got %b%b expected 10", aAcquireToken, bAcquireToken);
    end
    tick();
    release_owner();
  endtask

  task automatic test_random();
    int r;
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 149) != 0);
      masters($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      drive_slot(r < 3 ? T_TOKEN : (r < 7 ? T_NULL : 4'($urandom_range(2, 6))));
      settle();
      checks++;
      if (aAcquireToken !== e_acq_a || bAcquireToken !== e_acq_b || owner !== m_owner || errFlags !== m_err) begin
        errors++; $display("FAIL rand_ctl[%0d]: got acq %b%b owner %0d err %b expected %b%b %0d %b",
                           n, aAcquireToken, bAcquireToken, owner, errFlags, e_acq_a, e_acq_b, m_owner, m_err);
      end
      checks++;
      if (RingOut !== e_ring || SlotTypeOut !== e_type || SourceOut !== e_src) begin
        errors++; $display("FAIL rand_ring[%0d]: got %h/%h/%h expected %h/%h/%h",
                           n, RingOut, SlotTypeOut, SourceOut, e_ring, e_type, e_src);
      end
      tick();
    end
  endtask

  initial begin
    reset     = 1'b0;
    whichCore = CORE_ID;
    masters(0, 0, 0, 0);
    drive_slot(T_NULL);
    @(posedge clock);
    #1;
    test_reset();
    test_single_grant();
    test_both_want();
    test_no_wanter();
    test_overrun();
    test_errors();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_token_arbiter.md
# ring_token_arbiter

Per-core arbiter that shares the single ring token and ring output port between two local ring masters: port A is the coherent data cache and port B is the messenger/IO unit. It sits between the core's ring input (`RingIn`/`SlotTypeIn`/`SourceIn`) and the ring output register. It:
- captures the circulating Token slot for a requesting master;
- holds ownership while that master sends its burst;
- muxes the masters' ring outputs onto the ring;
- reinjects the token when the owner finishes.

Grants alternate round-robin between A and B.

## Interface
Parameters:
- `MAXHOLD`, default 16: hold-cycle count at which the overrun flag is set (8-bit compare).

Ports:
- `clock` input 1: single clock.
- `reset` input 1: synchronous, active-low reset.
- `whichCore` input 4: this core's ring ID, used as Source on the reinjected token.
- `RingIn` / `SlotTypeIn` / `SourceIn` input 32/4/4: incoming ring slot.
- `aWantsToken`, `bWantsToken` input 1: master requests the token.
- `aDriveRing`, `bDriveRing` input 1: master drives the ring this cycle.
- `aRingOut`/`aSlotTypeOut`/`aSourceOut`, `bRingOut`/`bSlotTypeOut`/`bSourceOut` input 32/4/4: master slot data.
- `aAcquireToken`, `bAcquireToken` output 1: token granted this cycle (combinational).
- `RingOut` / `SlotTypeOut` / `SourceOut` output 32/4/4: outgoing ring slot (combinational).
- `owner` output 2: 0 none, 1 A, 2 B (registered).
- `errFlags` output 3: sticky flags; bit0 drive collision, bit1 hold overrun, bit2 token seen while holding.

## Operation
Slot types: Null=7, Token=1.

State machine: IDLE, HOLD_A, HOLD_B, RELEASE. There is also a 1-bit round-robin pointer `rr` (0 means A has priority).

IDLE:
- A Token arrives and at least one master wants it: grant to the wanting master; if both want, grant per `rr`.
- The granted master's `xAcquireToken` is asserted in that same cycle. The master is required to drive in that cycle, which overwrites (consumes) the token.
- Next state is HOLD_x; clear `holdCnt`.
- A Token with no wanter passes through unchanged.

HOLD_x:
- `holdCnt` increments each cycle and saturates at 255.
- When `holdCnt == MAXHOLD`, set `errFlags[1]`. There is no forced release.
- A Token arriving in this state passes through and sets `errFlags[2]`.
- Release condition: `xWantsToken == 0 && xDriveRing == 0` for the owner. On release, go to RELEASE.

RELEASE:
- Reinjection happens in the first cycle with `SlotTypeIn == Null` and neither master driving.
- The reinjected slot is `RingOut = 0`, `SlotTypeOut = Token`, `SourceOut = whichCore`.
- In that cycle, toggle `rr` so the other master gets priority, and go to IDLE.
- While waiting, masters may drive non-token traffic, for example resends.

Output mux, valid in every state:
1. If the owner drives, its slot goes out.
2. Otherwise, if exactly one master drives, its slot goes out.
3. If both drive and neither owns the token, A wins and `errFlags[0]` is set.
4. During token reinjection, the Token slot goes out.
5. Otherwise `RingIn`/`SlotTypeIn`/`SourceIn` pass through.

Acquire outputs are asserted only in IDLE, and only on a Token slot.

Reset (`reset == 0` at a clock edge):
- State goes to IDLE; `rr`, `holdCnt`, `owner` and `errFlags` go to 0.
- While reset is low, both acquire outputs are 0 and the ring output is pass-through, unless a master drives.
- A reset during HOLD drops ownership without reinjecting the token. The token is lost; ring-level recovery belongs to the master core.

## Timing
- Grant latency is 0: acquire is combinational with the Token slot.
- `owner` updates on the next edge.
- Release is detected at cycle t, giving RELEASE at t+1. The token goes out at the first cycle ≥ t+1 with an incoming Null slot and no local driver, so the minimum release-to-token latency is 1 cycle.
- Ring output has no added latency. The external ring register provides the pipeline stage.
- Simultaneous Token arrival and both wants: exactly one acquire is asserted, selected by `rr`.
- Owner release and the other master's want in the same cycle: no direct hand-off. The token must circulate first.

## Test plan
- Reset, then Token arrives with `aWantsToken=1` only: `aAcquireToken=1` that cycle and `owner=1` next cycle. A drives 10 slots and then drops want and drive. The next Null slot becomes Token with Source=`whichCore`, and `rr=1`.
- Both masters want, Token arrives, `rr=0`: A is granted. After release and the token's return, both want again and B is granted.
- Token arrives with no wanters: passes through unchanged, `owner` stays 0, no acquire.
- A owns for 20 cycles with `MAXHOLD=16`: `errFlags[1]=1` from cycle 16, ownership is retained, and release still reinjects the token.
- Both masters drive in IDLE: A's slot goes out and `errFlags[0]=1`. Token arrives during HOLD_A: it passes through and `errFlags[2]=1`.
- `reset` pulled low mid-HOLD_B: the next cycle shows `owner=0`, `errFlags=0`, IDLE, and no Token injected.
